// File: rtl/fc_pkg.sv
// Shared types and geometry helpers for the fully-connected MAC engine.
package fc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } fc_state_t;

    typedef struct packed {
        int beats;
        int last_lanes;
    } fc_geom_t;

    // Beats per neuron and how many lanes carry real data on the final beat.
    function automatic fc_geom_t fc_geometry(input int lanes, input int in_len);
        fc_geom_t g;
        g.beats      = (in_len + lanes - 32'sd1) / lanes;
        g.last_lanes = in_len - (g.beats - 32'sd1) * lanes;
        return g;
    endfunction

endpackage

// File: rtl/fc_lane_dot.sv
// Masked signed multiply across LANES lanes, summed into an ACC_WIDTH result.
module fc_lane_dot #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int LANES      = 10
) (
    input  logic [LANES*DATA_WIDTH-1:0] act,
    input  logic [LANES*DATA_WIDTH-1:0] wgt,
    input  logic [LANES-1:0]            lane_mask,
    output logic [ACC_WIDTH-1:0]        sum
);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    ext;

    // Sign-extend each enabled product and wrap-add it into the lane sum.
    always_comb begin
        sum  = '0;
        prod = '0;
        ext  = '0;
        for (int i = 0; i < LANES; i++) begin
            prod = $signed(act[i*DATA_WIDTH +: DATA_WIDTH]) * $signed(wgt[i*DATA_WIDTH +: DATA_WIDTH]);
            ext  = lane_mask[i] ? ACC_WIDTH'(prod) : '0;
            sum  = sum + ext;
        end
    end

endmodule

// File: rtl/fc_mac_engine.sv
// Fully-connected layer engine: streams LANES pairs per beat, emits one biased dot product per neuron.
// Optional output ReLU clamp is enabled by defining FC_RELU_EN.
module fc_mac_engine
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ACC_WIDTH   = 32,
    parameter int LANES       = 10,
    parameter int IN_LEN      = 1024,
    parameter int OUT_NEURONS = 1000
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            clear,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]     in_act,
    input  logic [LANES*DATA_WIDTH-1:0]     in_wgt,
    input  logic [ACC_WIDTH-1:0]            in_bias,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [ACC_WIDTH-1:0]            out_data,
    output logic [$clog2(OUT_NEURONS)-1:0]  out_index,
    output logic                            busy,
    output logic                            done
);

    localparam fc_geom_t GEOM       = fc_geometry(LANES, IN_LEN);
    localparam int       BEATS      = GEOM.beats;
    localparam int       LAST_LANES = GEOM.last_lanes;
    localparam int       BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int       IDX_W      = $clog2(OUT_NEURONS);

    localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BEATS - 1);
    localparam logic [IDX_W-1:0]  LAST_NEURON = IDX_W'(OUT_NEURONS - 1);
    localparam logic [LANES-1:0]  TAIL_MASK   = {LANES{1'b1}} >> (LANES - LAST_LANES);

    fc_state_t              state;
    logic [BEAT_W-1:0]      beat;
    logic [ACC_WIDTH-1:0]   acc;
    logic [ACC_WIDTH-1:0]   lane_sum;
    logic [LANES-1:0]       lane_mask;

    // Padding lanes past IN_LEN only exist on the final beat of a neuron.
    assign lane_mask = (beat == LAST_BEAT) ? TAIL_MASK : {LANES{1'b1}};

    fc_lane_dot #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .LANES      (LANES)
    ) u_lane_dot (
        .act       (in_act),
        .wgt       (in_wgt),
        .lane_mask (lane_mask),
        .sum       (lane_sum)
    );

    // Control FSM with counters, accumulator and registered handshake/status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            beat      <= '0;
            out_index <= '0;
            acc       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            beat      <= '0;
            out_index <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= ACCUM;
                        beat      <= '0;
                        out_index <= '0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCUM: begin
                    if (in_valid && in_ready) begin
                        // Bias is folded in with the first beat so it is added exactly once.
                        acc <= ((beat == '0) ? in_bias : acc) + lane_sum;
                        if (beat == LAST_BEAT) begin
                            state     <= EMIT;
                            beat      <= '0;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            beat <= beat + BEAT_W'(1);
                        end
                    end else begin
                        state <= ACCUM;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_index == LAST_NEURON) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= ACCUM;
                            out_index <= out_index + IDX_W'(1);
                            beat      <= '0;
                            in_ready  <= 1'b1;
                        end
                    end else begin
                        state <= EMIT;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    beat      <= '0;
                    out_index <= '0;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

`ifdef FC_RELU_EN
    assign out_data = acc[ACC_WIDTH-1] ? '0 : acc;
`else
    assign out_data = acc;
`endif

endmodule

// File: tb/tb_fc_mac_engine.sv
// Directed, table-driven bench for fc_mac_engine with LANES=4, IN_LEN=10, OUT_NEURONS=2.
module tb_fc_mac_engine;

    localparam int DW = 8;
    localparam int AW = 32;
    localparam int LN = 4;

    logic           clock = 1'b0;
    logic           reset;
    logic           start, clear, in_valid, out_ready;
    logic [LN*DW-1:0] in_act, in_wgt;
    logic [AW-1:0]  in_bias;
    logic           in_ready, out_valid, busy, done;
    logic [AW-1:0]  out_data;
    logic [0:0]     out_index;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0]  act;
        logic [7:0]  wgt;
        logic [7:0]  pad;
        logic [31:0] bias0;
        logic [31:0] bias1;
        logic [31:0] exp0;
        logic [31:0] exp1;
        int          gap;
        int          hold;
    } vec_t;

    vec_t vecs [6];
    vec_t cv;

    fc_mac_engine #(
        .DATA_WIDTH (DW), .ACC_WIDTH (AW), .LANES (LN), .IN_LEN (10), .OUT_NEURONS (2)
    ) dut (
        .clock (clock), .reset (reset), .start (start), .clear (clear),
        .in_valid (in_valid), .in_ready (in_ready), .in_act (in_act), .in_wgt (in_wgt),
        .in_bias (in_bias), .out_valid (out_valid), .out_ready (out_ready),
        .out_data (out_data), .out_index (out_index), .busy (busy), .done (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, $signed(act), act, $signed(exp), exp);
        end
    endtask

    function automatic logic [31:0] expv(input logic [31:0] x);
`ifdef FC_RELU_EN
        return x[31] ? 32'd0 : x;
`else
        return x;
`endif
    endfunction

    task automatic drive_beat(input vec_t v, input int b);
        for (int l = 0; l < LN; l++) begin
            in_act[l*DW +: DW] = (b == 2 && l >= 2) ? v.pad : v.act;
            in_wgt[l*DW +: DW] = (b == 2 && l >= 2) ? v.pad : v.wgt;
        end
    endtask

    // Present one beat and hold it until the engine takes it.
    task automatic send_beat(input vec_t v, input logic [31:0] bias, input int b);
        int k;
        in_valid = 1'b1;
        drive_beat(v, b);
        in_bias = (b == 0) ? bias : ~bias;
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clock);
            k++;
        end
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        @(negedge clock);
    endtask

    task automatic run_layer(input vec_t v);
        logic [31:0] bias;
        logic [31:0] exp;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        for (int n = 0; n < 2; n++) begin
            bias = (n == 0) ? v.bias0 : v.bias1;
            exp  = expv((n == 0) ? v.exp0 : v.exp1);
            for (int b = 0; b < 3; b++) begin
                if (v.gap != 0) begin
                    in_valid = 1'b0;
                    drive_beat(v, 2);
                    in_bias = 32'hDEAD_BEEF;
                    @(negedge clock);
                end
                start = (n == 0 && b == 1);
                send_beat(v, bias, b);
                start = 1'b0;
            end
            in_valid = 1'b0;
            check("out_valid_rise", {31'd0, out_valid}, 32'd1);
            check("out_data", out_data, exp);
            check("out_index", {31'd0, out_index}, n);
            check("in_ready_emit", {31'd0, in_ready}, 32'd0);
            for (int h = 0; h < v.hold; h++) begin
                @(negedge clock);
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_data", out_data, exp);
                check("hold_index", {31'd0, out_index}, n);
                check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            end
            out_ready = 1'b1;
            @(negedge clock);
            out_ready = 1'b0;
            check("out_valid_fall", {31'd0, out_valid}, 32'd0);
            if (n == 1) begin
                check("done_pulse", {31'd0, done}, 32'd1);
                @(negedge clock);
                check("done_clear", {31'd0, done}, 32'd0);
                check("busy_idle", {31'd0, busy}, 32'd0);
            end else begin
                check("no_early_done", {31'd0, done}, 32'd0);
                check("in_ready_next", {31'd0, in_ready}, 32'd1);
            end
        end
    endtask

    initial begin
        vecs[0] = '{8'h01, 8'h02, 8'h7F, 32'd5, 32'd5, 32'd25, 32'd25, 0, 0};
        vecs[1] = '{8'h80, 8'h7F, 8'h7F, 32'd0, 32'd0, -32'sd162560, -32'sd162560, 0, 5};
        vecs[2] = '{8'h03, 8'hFC, 8'h80, 32'd100, -32'sd7, -32'sd20, -32'sd127, 1, 0};
        vecs[3] = '{8'h01, 8'h02, 8'h7F, 32'd5, 32'd5, 32'd25, 32'd25, 1, 2};
        vecs[4] = '{8'h7F, 8'h7F, 8'h01, 32'hFFFF_FFFF, 32'd1000, 32'd161289, 32'd162290, 0, 0};
        vecs[5] = '{8'hFF, 8'hFF, 8'h7F, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0009, 32'h8000_000A, 0, 0};

        reset = 1'b1; start = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_act = '0; in_wgt = '0; in_bias = '0;
        #3;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_index", {31'd0, out_index}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 6; i++) begin
            run_layer(vecs[i]);
            @(negedge clock);
        end

        // Abort after two beats of neuron 0, then rerun with a new bias.
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        send_beat(vecs[0], 32'd5, 0);
        send_beat(vecs[0], 32'd5, 1);
        in_valid = 1'b0;
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        check("clear_busy", {31'd0, busy}, 32'd0);
        check("clear_in_ready", {31'd0, in_ready}, 32'd0);
        check("clear_out_valid", {31'd0, out_valid}, 32'd0);
        repeat (3) begin
            @(negedge clock);
            check("clear_no_valid", {31'd0, out_valid}, 32'd0);
        end
        cv = '{8'h01, 8'h02, 8'h7F, 32'd9, 32'd9, 32'd29, 32'd29, 0, 0};
        run_layer(cv);
        @(negedge clock);

        // Asynchronous reset while a result is waiting in EMIT.
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int b = 0; b < 3; b++) send_beat(vecs[0], 32'd5, b);
        in_valid = 1'b0;
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_out_data", out_data, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        run_layer(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fc_mac_engine.md
# fc_mac_engine

Parametrised fully-connected layer engine for the MobileNet classifier head. It computes OUT_NEURONS signed dot products, each of length IN_LEN, consuming LANES activation/weight pairs per beat over a valid/ready stream. Each neuron's bias is added once, and the engine emits one accumulated result per neuron on a backpressured output stream. It sits between the global-average-pool output buffer and the softmax/argmax stage.

## Interface
- DATA_WIDTH, 8, activation/weight width (signed two's complement)
- ACC_WIDTH, 32, accumulator, bias and result width (signed)
- LANES, 10, multiply lanes per beat
- IN_LEN, 1024, dot-product length per neuron
- OUT_NEURONS, 1000, neurons per layer run
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- start  in  1  begins a layer run; honoured only in IDLE
- clear  in  1  synchronous abort to IDLE; discards partial work
- in_valid  in  1  input beat valid
- in_ready  out  1  engine accepts a beat
- in_act  in  LANES*DATA_WIDTH  packed activations, lane 0 in LSBs
- in_wgt  in  LANES*DATA_WIDTH  packed weights, lane 0 in LSBs
- in_bias  in  ACC_WIDTH  current neuron bias; sampled with that neuron's first beat
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  ACC_WIDTH  neuron result
- out_index  out  $clog2(OUT_NEURONS)  neuron number of out_data
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last neuron is emitted

## Operation
- BEATS = ceil(IN_LEN/LANES) beats per neuron. On the final beat, lanes with index ≥ IN_LEN − (BEATS−1)·LANES contribute zero, whatever their data.
- Products are signed, 2·DATA_WIDTH wide, and sign-extended to ACC_WIDTH. The lane sum and accumulation wrap modulo 2^ACC_WIDTH.
- The first beat of a neuron loads acc = in_bias + lane_sum. Later beats do acc += lane_sum.
- States:
  - IDLE: on start → ACCUM with neuron = 0 and beat = 0.
  - ACCUM: in_ready = 1. On each beat handshake, update acc and beat. On the handshake of beat BEATS−1 → EMIT.
  - EMIT: out_valid = 1, out_data = acc, out_index = neuron. On out_valid && out_ready: if neuron = OUT_NEURONS−1 → DONE; otherwise neuron += 1, beat = 0, → ACCUM.
  - DONE: done = 1 for one cycle, then → IDLE.
- clear has priority over every other event in the same cycle. It forces IDLE and zeroes beat, neuron, out_valid and done; acc is don't-care.
- start outside IDLE is ignored. in_valid outside ACCUM is ignored.
- Reset values: in_ready 0, out_valid 0, out_data 0, out_index 0, busy 0, done 0; state IDLE, counters 0.

## Timing
- Full throughput is one beat per cycle while in_valid stays high.
- out_valid rises the cycle after the last beat handshake.
- Each neuron costs BEATS + 1 cycles minimum: the EMIT cycle blocks input (in_ready = 0).
- out_data and out_index stay stable while out_valid && !out_ready.
- done rises the cycle after the final output handshake.
- Minimum run length: OUT_NEURONS·(BEATS+1) + 1 cycles from the start cycle.
- Reset asserted at any point returns all outputs to their reset values immediately, with no clock required.

## Configuration
- FC_RELU_EN defined: out_data = 0 when acc is negative, otherwise acc. The clamp is applied combinationally at the output; acc itself is unchanged.
- FC_RELU_EN undefined: out_data = acc, raw signed result.

## Structure
- Package fc_pkg holds:
  - the state enum fc_state_t {IDLE, ACCUM, EMIT, DONE};
  - a function computing BEATS and the last-beat valid-lane count from LANES and IN_LEN.
- Sub-module fc_lane_dot: combinational masked signed multiply and adder tree over LANES lanes, with a lane-enable mask input, producing an ACC_WIDTH sum. fc_mac_engine holds the FSM, counters, accumulator and output register.

## Test plan
- LANES=4, IN_LEN=10, OUT_NEURONS=2. All acts 1, wgts 2, bias 5; final-beat lanes 2–3 driven to 0x7F → out_data 25 with out_index 0, then 25 with index 1, then one done pulse.
- Same configuration, acts −128, wgts 127, bias 0 → out_data −162560. With FC_RELU_EN defined → out_data 0.
- out_ready held low for 5 cycles in EMIT → out_valid stays high, out_data and out_index stable, in_ready 0. After release, the next neuron proceeds normally.
- in_valid toggled every other cycle → results identical to continuous input; acc changes only on handshake cycles.
- clear asserted after 2 beats of neuron 0 → IDLE the next cycle, busy 0, no out_valid. A fresh start then yields correct results from a new bias.
- start pulsed during ACCUM → ignored. reset asserted in EMIT → out_valid 0, out_data 0, busy 0 immediately.
